// File: rtl/serial_bus_arbiter_nm.sv
// serial_bus_arbiter_nm
// Multi-master arbiter and serial address decoder for the serial system bus.
// A granted master shifts in an ADDR_W-bit slave address (MSB first). A valid
// address connects the master to that slave for DATA_CYCLES cycles. An
// out-of-range address is rejected without touching any slave.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, arbitration
// is round-robin. When it is undefined, the lowest requesting index wins.
module serial_bus_arbiter_nm #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 3,
  parameter int DATA_CYCLES = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_mode,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_SLAVES-1:0]  s_mode,
  output logic [NUM_SLAVES-1:0]  s_wr_bus,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  input  logic [NUM_SLAVES-1:0]  s_rd_bus,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  input  logic [NUM_SLAVES-1:0]  s_slave_valid
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int BW = $clog2(ADDR_W + 1);
  localparam int DW = $clog2(DATA_CYCLES + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ADDR      = 2'd1;
  localparam logic [1:0] ST_CONNECTED = 2'd2;
  localparam logic [1:0] ST_CLEAN     = 2'd3;

  logic [1:0]        state_r;
  logic [GW-1:0]     gnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [BW-1:0]     bitcnt_r;
  logic [DW-1:0]     datcnt_r;
  logic              ack_q_r;
  logic [SW-1:0]     sel_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0]     rr_ptr_r;
  logic              found_s;
`endif

  logic [GW-1:0]     winner_s;
  logic [GW-1:0]     idx_s;
  logic [ADDR_W-1:0] addr_shift_s;
  logic              addr_hit_s;
  logic              last_bit_s;
  logic              data_last_s;
  logic              gnt_valid_s;

  // Pick the master that wins arbitration this cycle.
  always_comb begin
    winner_s = '0;
    idx_s    = '0;
`ifdef ARB_ROUND_ROBIN_EN
    // Scan from the round-robin pointer upwards; the first requester wins.
    found_s = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx_s = GW'((int'(rr_ptr_r) + k) % NUM_MASTERS);
      if (!found_s && m_master_valid[idx_s]) begin
        winner_s = idx_s;
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
      end
    end
`else
    // Scan from the top down so that the lowest requester is written last.
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx_s = GW'(k);
      if (m_master_valid[idx_s]) begin
        winner_s = idx_s;
      end else begin
        winner_s = winner_s;
      end
    end
`endif
  end

  // Build the address as it would look after taking the current bit, and decode it.
  always_comb begin
    gnt_valid_s  = m_master_valid[gnt_r];
    addr_shift_s = ADDR_W'({addr_r, m_wr_bus[gnt_r]});
    addr_hit_s   = (32'(addr_shift_s) < 32'(NUM_SLAVES));
    last_bit_s   = (bitcnt_r == BW'(ADDR_W - 1));
    data_last_s  = (datcnt_r == DW'(DATA_CYCLES - 1));
  end

  // Transfer sequencing: arbitration, address shift and decode, data-phase count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      gnt_r    <= '0;
      addr_r   <= '0;
      bitcnt_r <= '0;
      datcnt_r <= '0;
      ack_q_r  <= 1'b0;
      sel_r    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_r <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|m_master_valid) begin
            gnt_r   <= winner_s;
            state_r <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // A low valid from the granted master stalls the address phase.
          if (gnt_valid_s) begin
            addr_r   <= addr_shift_s;
            bitcnt_r <= bitcnt_r + BW'(1);
            if (last_bit_s) begin
              if (addr_hit_s) begin
                sel_r   <= SW'(addr_shift_s);
                ack_q_r <= 1'b1;
                state_r <= ST_CONNECTED;
              end else begin
                ack_q_r <= 1'b0;
                state_r <= ST_CLEAN;
              end
            end
          end
        end
        ST_CONNECTED: begin
          // The data phase has a fixed length and ignores the handshakes.
          datcnt_r <= datcnt_r + DW'(1);
          if (data_last_s) begin
            state_r <= ST_CLEAN;
          end
        end
        ST_CLEAN: begin
          addr_r   <= '0;
          bitcnt_r <= '0;
          datcnt_r <= '0;
          ack_q_r  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_r <= GW'((int'(gnt_r) + 1) % NUM_MASTERS);
`endif
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive grant/ack and route the granted master to the selected slave; all else stays 0.
  always_comb begin
    m_rd_bus       = '0;
    m_ack          = '0;
    m_slave_ready  = '0;
    m_slave_valid  = '0;
    m_grant        = '0;
    s_mode         = '0;
    s_wr_bus       = '0;
    s_master_valid = '0;
    s_master_ready = '0;
    case (state_r)
      ST_ADDR: begin
        m_grant[gnt_r]       = 1'b1;
        m_slave_ready[gnt_r] = 1'b1;
      end
      ST_CONNECTED: begin
        m_grant[gnt_r]        = 1'b1;
        m_ack[gnt_r]          = ack_q_r;
        s_mode[sel_r]         = m_mode[gnt_r];
        s_wr_bus[sel_r]       = m_wr_bus[gnt_r];
        s_master_valid[sel_r] = m_master_valid[gnt_r];
        s_master_ready[sel_r] = m_master_ready[gnt_r];
        m_rd_bus[gnt_r]       = s_rd_bus[sel_r];
        m_slave_ready[gnt_r]  = s_slave_ready[sel_r];
        m_slave_valid[gnt_r]  = s_slave_valid[sel_r];
      end
      default: begin
        m_grant = '0;
      end
    endcase
  end

endmodule
